// File: rtl/uart_rx.sv
// 8N1 serial receiver: oversampled start/data/stop detection with a one-byte
// holding register, ready/ack handshake, framing-error and sticky overrun flags.
//
//   state   | meaning
//   IDLE    | line idle, waiting for a low sample
//   START   | qualifying start bit at its centre
//   DATA    | sampling data bits at bit centres
//   STOP    | sampling stop bit, loads holding register
//   WAIT_HI | break/framing error, waiting for line to return high
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_tick,
  input  logic       rx,
  input  logic       rd_ack,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HI
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_W-1:0]     bitcnt;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_nx;
  logic [7:0]           rx_byte;
  logic                 rx_m;
  logic                 rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // LSB arrives first, so each new sample enters at the top and shifts down.
  always_comb begin
    shreg_nx                = shreg >> 1;
    shreg_nx[DATA_BITS-1]   = rx_s;
    rx_byte                 = '0;
    rx_byte[DATA_BITS-1:0]  = shreg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bitcnt    <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_ready  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (rd_ack && rx_ready) begin
        rx_ready <= 1'b0;
        overrun  <= 1'b0;
      end

      if (sample_tick) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state <= START;
              cnt   <= '0;
              busy  <= 1'b1;
            end
          end

          START: begin
            if (cnt == CNT_HALF) begin
              cnt <= '0;
              if (rx_s) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state  <= DATA;
                bitcnt <= '0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          DATA: begin
            if (cnt == CNT_FULL) begin
              cnt   <= '0;
              shreg <= shreg_nx;
              if (bitcnt == BIT_LAST) begin
                state  <= STOP;
                bitcnt <= '0;
              end else begin
                bitcnt <= bitcnt + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          STOP: begin
            if (cnt == CNT_FULL) begin
              cnt   <= '0;
              state <= rx_s ? IDLE : WAIT_HI;
              busy  <= ~rx_s;
              // An ack in the same cycle frees the holder, so the new byte wins.
              if (!rx_ready || rd_ack) begin
                rx_data   <= rx_byte;
                frame_err <= ~rx_s;
                rx_ready  <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          WAIT_HI: begin
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end

          default: begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
